// File: rtl/serial_receiver_if.sv
// Signal bundle between the serial line/consumer side (master) and the 8N1 receiver (slave).
interface serial_receiver_if;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  modport master (output rx, input data, input data_valid, input frame_error, input busy);
  modport slave  (input rx, output data, output data_valid, output frame_error, output busy);
endinterface

// File: rtl/serial_receiver.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling, one-cycle valid / framing-error strobes.
module serial_receiver #(
  parameter int CLKS_PER_BIT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  serial_receiver_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [1:0]  r_sync_vld;
  logic        r_armed;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_data_valid;
  logic        r_frame_error;
  logic        r_busy;

  logic        w_rx_s;
  logic        w_half_done;
  logic        w_bit_done;
  logic        w_dv_next;
  logic        w_fe_next;
  logic        w_busy_next;

  assign w_rx_s      = r_sync2;
  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_bit_done  = (r_cnt == BIT_LAST);

  // The synchronizer resets to idle-high; r_sync_vld keeps those reset values from arming the
  // receiver, so a line held low through reset must really be seen high first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync_vld <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make both flops sample pre-edge values, giving two real stages.
      r_sync1    <= bus.rx;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (r_armed && !w_rx_s) w_next_state = S_START;
      S_START: if (w_half_done) w_next_state = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
      S_STOP:  if (w_bit_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_dv_next   = (r_state == S_STOP) && w_bit_done && w_rx_s;
    w_fe_next   = (r_state == S_STOP) && w_bit_done && !w_rx_s;
    w_busy_next = (w_next_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_bit_idx     <= 3'd0;
      r_shift       <= 8'h00;
      r_data        <= 8'h00;
      r_armed       <= 1'b0;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_data_valid  <= w_dv_next;
      r_frame_error <= w_fe_next;
      r_busy        <= w_busy_next;

      if (w_fe_next)                    r_armed <= 1'b0;
      else if (w_rx_s && r_sync_vld[1]) r_armed <= 1'b1;

      case (r_state)
        S_IDLE:  r_cnt <= '0;
        S_START: r_cnt <= w_half_done ? '0 : r_cnt + 1'b1;
        default: r_cnt <= w_bit_done  ? '0 : r_cnt + 1'b1;
      endcase

      if ((r_state == S_START) && w_half_done) r_bit_idx <= 3'd0;
      else if ((r_state == S_DATA) && w_bit_done) begin
        r_bit_idx <= r_bit_idx + 3'd1;
        r_shift   <= {w_rx_s, r_shift[7:1]};
      end

      if (w_dv_next) r_data <= r_shift;
    end
  end

  assign bus.data        = r_data;
  assign bus.data_valid  = r_data_valid;
  assign bus.frame_error = r_frame_error;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: one 16-clock-per-bit instance and one 1000-clock-per-bit instance.
module tb_serial_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_receiver_if bus16 ();
  serial_receiver_if bus1k ();

  serial_receiver #(.CLKS_PER_BIT(16))   dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  serial_receiver #(.CLKS_PER_BIT(1000)) dut1k (.clk(clk), .rst(rst), .bus(bus1k.slave));

  int n_cmp = 0;
  int n_err = 0;

  // Edge index: after rising edge n (and its NBA region) cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   dv16_cnt = 0, dv16_last = 0, dv16_prev = 0;
  int   fe16_cnt = 0, fe16_last = 0;
  int   busy16_rise = 0, busy16_fall = 0, busy16_rise_cnt = 0;
  int   dv1k_cnt = 0, dv1k_last = 0, fe1k_cnt = 0;
  int   both_cnt = 0;
  logic busy16_q = 1'b0;

  always @(negedge clk) begin
    busy16_q <= bus16.busy;
    if (bus16.data_valid) begin
      dv16_cnt  <= dv16_cnt + 1;
      dv16_prev <= dv16_last;
      dv16_last <= cyc;
    end
    if (bus16.frame_error) begin
      fe16_cnt  <= fe16_cnt + 1;
      fe16_last <= cyc;
    end
    if (bus16.busy && !busy16_q) begin
      busy16_rise     <= cyc;
      busy16_rise_cnt <= busy16_rise_cnt + 1;
    end
    if (!bus16.busy && busy16_q) busy16_fall <= cyc;
    if (bus1k.data_valid) begin
      dv1k_cnt  <= dv1k_cnt + 1;
      dv1k_last <= cyc;
    end
    if (bus1k.frame_error) fe1k_cnt <= fe1k_cnt + 1;
    if ((bus16.data_valid && bus16.frame_error) || (bus1k.data_valid && bus1k.frame_error))
      both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) bus1k.rx = v;
    else     bus16.rx = v;
  endtask

  // Called at #1 after an edge; returns at #1 after the edge that ends the stop bit.
  task automatic send(input bit sel, input int c, input logic [7:0] b, input logic stop,
                      output int t0);
    set_rx(sel, 1'b0);
    t0 = cyc + 1;
    repeat (c) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      repeat (c) @(posedge clk);
      #1;
    end
    set_rx(sel, stop);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0, t0b, dv0, fe0, rc0;

  initial begin
    bus16.rx = 1'b1;
    bus1k.rx = 1'b1;
    #22;
    check("rst_data",   {24'd0, bus16.data}, 32'h00);
    check("rst_dv",     {31'd0, bus16.data_valid}, 32'd0);
    check("rst_fe",     {31'd0, bus16.frame_error}, 32'd0);
    check("rst_busy",   {31'd0, bus16.busy}, 32'd0);
    check("rst_data1k", {24'd0, bus1k.data}, 32'h00);
    #1 rst = 1'b0;

    // 0x55 with t0 = 100: stop sample at edge 254
    while (cyc != 99) begin
      @(posedge clk);
      #1;
    end
    dv0 = dv16_cnt; fe0 = fe16_cnt;
    send(1'b0, 16, 8'h55, 1'b1, t0);
    idle(5);
    check("f55_data",   {24'd0, bus16.data}, 32'h55);
    check("f55_dv_cnt", dv16_cnt - dv0, 1);
    check("f55_dv_edge", dv16_last, 254);
    check("f55_fe_cnt", fe16_cnt - fe0, 0);
    check("f55_busy_rise", busy16_rise, 102);
    check("f55_busy_fall", busy16_fall, 254);

    // 0xA3 then 0x0F with no idle gap
    idle(10);
    dv0 = dv16_cnt; fe0 = fe16_cnt;
    send(1'b0, 16, 8'hA3, 1'b1, t0);
    check("b2b_data_a3", {24'd0, bus16.data}, 32'hA3);
    send(1'b0, 16, 8'h0F, 1'b1, t0b);
    idle(5);
    check("b2b_data_0f", {24'd0, bus16.data}, 32'h0F);
    check("b2b_dv_cnt",  dv16_cnt - dv0, 2);
    check("b2b_spacing", dv16_last - dv16_prev, 160);
    check("b2b_fe_cnt",  fe16_cnt - fe0, 0);

    // 3-cycle glitch, then a good frame 20 cycles later
    idle(10);
    dv0 = dv16_cnt; fe0 = fe16_cnt;
    bus16.rx = 1'b0;
    t0 = cyc + 1;
    idle(3);
    bus16.rx = 1'b1;
    idle(20);
    check("glitch_busy_len",  busy16_fall - busy16_rise, 8);
    check("glitch_busy_rise", busy16_rise, t0 + 2);
    check("glitch_dv_cnt",    dv16_cnt - dv0, 0);
    check("glitch_fe_cnt",    fe16_cnt - fe0, 0);
    check("glitch_data",      {24'd0, bus16.data}, 32'h0F);
    send(1'b0, 16, 8'h96, 1'b1, t0);
    idle(5);
    check("post_glitch_data", {24'd0, bus16.data}, 32'h96);
    check("post_glitch_dv",   dv16_cnt - dv0, 1);

    // 0x3C with stop bit low, line held low for 50 bit times
    idle(10);
    dv0 = dv16_cnt; fe0 = fe16_cnt; rc0 = busy16_rise_cnt;
    send(1'b0, 16, 8'h3C, 1'b0, t0);
    idle(50 * 16);
    check("ferr_fe_cnt",   fe16_cnt - fe0, 1);
    check("ferr_fe_edge",  fe16_last, t0 + 154);
    check("ferr_dv_cnt",   dv16_cnt - dv0, 0);
    check("ferr_data",     {24'd0, bus16.data}, 32'h96);
    check("ferr_busy_fall", busy16_fall, t0 + 154);
    check("ferr_busy_rises", busy16_rise_cnt - rc0, 1);
    bus16.rx = 1'b1;
    idle(5);
    send(1'b0, 16, 8'hC3, 1'b1, t0);
    idle(5);
    check("post_ferr_data", {24'd0, bus16.data}, 32'hC3);
    check("post_ferr_dv",   dv16_cnt - dv0, 1);
    check("post_ferr_fe",   fe16_cnt - fe0, 1);

    // Asynchronous reset in the middle of data bit 4
    idle(10);
    dv0 = dv16_cnt; fe0 = fe16_cnt;
    bus16.rx = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      bus16.rx = 1'b1;
      idle(16);
    end
    bus16.rx = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("mid_busy_before", {31'd0, bus16.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus16.busy}, 32'd0);
    check("arst_data", {24'd0, bus16.data}, 32'h00);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    rc0 = busy16_rise_cnt;
    idle(200);
    check("arst_low_no_start", busy16_rise_cnt - rc0, 0);
    check("arst_no_dv",        dv16_cnt - dv0, 0);
    check("arst_no_fe",        fe16_cnt - fe0, 0);
    bus16.rx = 1'b1;
    idle(20);
    send(1'b0, 16, 8'h81, 1'b1, t0);
    idle(5);
    check("arst_81_data", {24'd0, bus16.data}, 32'h81);
    check("arst_81_dv",   dv16_cnt - dv0, 1);

    // CLKS_PER_BIT = 1000: 0xFF then 0x00
    idle(20);
    dv0 = dv1k_cnt;
    send(1'b1, 1000, 8'hFF, 1'b1, t0);
    idle(5);
    check("k_ff_edge", dv1k_last, t0 + 9502);
    check("k_ff_data", {24'd0, bus1k.data}, 32'hFF);
    idle(50);
    send(1'b1, 1000, 8'h00, 1'b1, t0);
    idle(5);
    check("k_00_edge", dv1k_last, t0 + 9502);
    check("k_00_data", {24'd0, bus1k.data}, 32'h00);
    check("k_dv_cnt",  dv1k_cnt - dv0, 2);
    check("k_fe_cnt",  fe1k_cnt, 0);

    check("strobes_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Serial 8N1 receiver, the receiving end of the team's serial link; its bit period matches the transmitter-clock generator tick (CLKS_PER_BIT = 1000 → 100 kbaud at 100 MHz). It synchronizes the asynchronous `rx` line, detects start bits, samples each bit at mid-period, and delivers one byte per frame as a single-cycle `data_valid` strobe. Framing errors are flagged, not delivered.

## Interface
- CLKS_PER_BIT, 1000, clk cycles per serial bit; even, ≥ 4.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  serial line, idle high, asynchronous to clk.
- data  out  8  last good byte, LSB received first.
- data_valid  out  1  one-cycle strobe: `data` just updated.
- frame_error  out  1  one-cycle strobe: stop bit sampled low.
- busy  out  1  high while a frame is in progress (START/DATA/STOP).

## Operation
- **Synchronizer and bit timing**
  - `rx` passes through two flops (sync1, sync2); sync2 = rx_s.
  - Bit counter is $clog2(CLKS_PER_BIT) bits wide. H = CLKS_PER_BIT/2.
- **armed flag**
  - Cleared by reset and by a framing error.
  - Set on any cycle with rx_s = 1.
  - A start bit is accepted only while armed = 1.
- **State machine** (IDLE, START, DATA, STOP)
  - IDLE: if armed and rx_s = 0, go to START with counter = 0.
  - START: count up. At counter = H-1:
    - rx_s = 0: go to DATA, counter = 0, bit index = 0.
    - rx_s = 1: glitch; go to IDLE with no strobe.
  - DATA: at counter = C-1, shift rx_s into the shift register MSB side so the first bit ends at bit 0, increment the bit index, and reset the counter. After the 8th sample, go to STOP.
  - STOP: at counter = C-1, sample rx_s:
    - 1: `data` ← shift register, pulse data_valid.
    - 0: pulse frame_error, `data` unchanged, clear armed.
    - Either way, go to IDLE (mid stop bit), so a back-to-back start edge is caught.
- **Strobes**
  - data_valid and frame_error are never high together.
  - Each is high for exactly one cycle.
- **busy**: registered; equals (state ≠ IDLE).
- **Reset** (asynchronous, any state, including mid-frame):
  - Outputs: data = 0x00, data_valid = 0, frame_error = 0, busy = 0.
  - Internal: sync1 = sync2 = 1, state = IDLE, armed = 0, counter = 0, shift register = 0.
  - An aborted frame produces no strobe.
  - After release, a held-low `rx` must go high before the next frame is accepted.

## Timing
- Let t0 be the first rising clk edge that samples rx = 0 into sync1:
  - rx_s low after edge t0+1.
  - START entered at edge t0+2.
  - DATA entered at edge t0+2+H.
  - Data bit k (k = 1..8) sampled at edge t0+2+H+k·C.
- The stop sample at edge t0+2+H+9·C registers data_valid or frame_error high for the following cycle.
  - For C = 1000, that edge is t0+9502.
- busy rises at edge t0+2 and falls at the same edge the strobe rises.
- Back-to-back frames (no idle): the next falling edge arrives H cycles after the stop sample. Accepted because armed was set during the high stop bit.
- Receiver tolerates sender clock error up to ±4% (sampling at mid-bit).

## Test plan
- CLKS_PER_BIT = 16, reset, send 0x55 with t0 = 100 → data = 0x55; data_valid high only in the cycle after edge 254; frame_error stays 0; busy high from edge 102 to edge 254.
- CLKS_PER_BIT = 16, send 0xA3 then 0x0F with no idle gap → two data_valid pulses exactly 160 cycles apart; data = 0xA3, then 0x0F; no frame_error.
- rx low for 3 cycles, then high → busy pulses high for H = 8 cycles; no data_valid, no frame_error; data unchanged; a correct frame 20 cycles later decodes normally.
- Frame 0x3C with stop bit forced 0, line then held low for 50 bit times → frame_error pulses once; data keeps its prior value; no further strobes or busy until rx returns high. The next 0xC3 frame is received correctly.
- rst asserted mid data bit 4 (between clock edges) → busy and data go to 0 immediately, without waiting for a clock edge. Release with rx held low → no frame starts. Raise rx, send 0x81 → data = 0x81 with one data_valid pulse.
- CLKS_PER_BIT = 1000, send 0xFF and then 0x00 → data_valid at t0+9502 for each; data = 0xFF, then 0x00.
